// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the UART example blocks:
//                ASCII line terminators, default clock/baud rates and the
//                transmit-arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // ASCII line terminators
    localparam logic [7:0] CHAR_LF = 8'h0a;
    localparam logic [7:0] CHAR_CR = 8'h0d;

    // Defaults used across the UART examples
    localparam int CLOCK_RATE_HZ = 25_000_000;
    localparam int BAUD_RATE     = 115_200;

    // Transmit arbiter FSM: waiting for a requester, or one source owns the line
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Source-side byte streams and txuart stb/busy handshake of the
//                transmit arbiter, plus its grant/busy status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NSRC = 2
);
    logic [NSRC-1:0]   i_valid;    // source n has a byte ready
    logic [8*NSRC-1:0] i_data;     // byte of source n in [8n+7:8n]
    logic [NSRC-1:0]   o_ready;    // byte of source n consumed this cycle
    logic              o_tx_stb;   // to txuart i_wr
    logic [7:0]        o_tx_data;  // to txuart i_data
    logic              i_tx_busy;  // from txuart o_busy
    logic [NSRC-1:0]   o_grant;    // one-hot current owner
    logic              o_busy;     // a grant is active

    // Arbiter side
    modport slave (
        input  i_valid, i_data, i_tx_busy,
        output o_ready, o_tx_stb, o_tx_data, o_grant, o_busy
    );

    // Environment side (sources and txuart)
    modport master (
        output i_valid, i_data, i_tx_busy,
        input  o_ready, o_tx_stb, o_tx_data, o_grant, o_busy
    );
endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches the request
//                vector upward starting just above the last owner (wrapping)
//                and returns the first requester as one-hot and as an index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_last,
    output logic      [N-1:0]  o_grant,
    output logic      [IW-1:0] o_idx,
    output logic               o_any
);

    // First requester after i_last, modulo N; lower distance wins
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(i_last) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IW'(j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one txuart between NSRC byte-stream sources at line
//                granularity. A grant lasts until an end-of-line byte, MAXLEN
//                bytes, or TIMEOUT idle clocks; the next owner is chosen
//                round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NSRC    = 2,
    parameter int MAXLEN  = 80,
    parameter int TIMEOUT = 25_000_000,
    parameter int EOL_CR  = 0
) (
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int BW = $clog2(MAXLEN + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Count value held while the final byte of a maximum-length line is taken
    localparam logic [BW-1:0] BYTE_LAST = BW'(MAXLEN - 1);
    localparam logic [BW-1:0] BYTE_MAX  = BW'(MAXLEN);
    // Idle count value whose increment reaches TIMEOUT
    localparam logic [TW-1:0] IDLE_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] IDLE_MAX  = (TIMEOUT > 0) ? TW'(TIMEOUT) : '1;

    arb_state_t      state_q, state_d;
    logic [NSRC-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   idle_cnt_q, idle_cnt_d;

    logic [NSRC-1:0] w_pick_grant;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;

    logic [7:0]      w_src_byte [NSRC];
    logic            w_sel_valid;
    logic [7:0]      w_sel_data;
    logic            w_is_eol;
    logic            w_accept;
    logic            w_tx_stb;
    logic [7:0]      w_tx_data;
    logic [NSRC-1:0] w_ready;

    rr_pick #(
        .N  (NSRC),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (bus.i_valid),
        .i_last  (last_q),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    for (genvar n = 0; n < NSRC; n++) begin : g_unpack
        assign w_src_byte[n] = bus.i_data[8*n +: 8];
    end

    assign w_sel_valid = bus.i_valid[owner_q];
    assign w_sel_data  = w_src_byte[owner_q];
    assign w_is_eol    = (w_sel_data == CHAR_LF) ||
                         ((EOL_CR != 0) && (w_sel_data == CHAR_CR));

    // Arbitration, line tracking and the zero-latency txuart handshake
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        w_tx_stb   = 1'b0;
        w_tx_data  = 8'h00;
        w_ready    = '0;
        w_accept   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    grant_d    = w_pick_grant;
                    owner_d    = w_pick_idx;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                w_tx_stb  = w_sel_valid;
                w_tx_data = w_sel_data;
                w_ready   = grant_q & {NSRC{~bus.i_tx_busy}};
                w_accept  = w_sel_valid && !bus.i_tx_busy;

                if (w_accept) begin
                    byte_cnt_d = (byte_cnt_q == BYTE_MAX) ? byte_cnt_q
                                                          : byte_cnt_q + BW'(1);
                    idle_cnt_d = '0;
                    // Terminator and length limit coinciding release only once
                    if (w_is_eol || (byte_cnt_q == BYTE_LAST)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end else if (bus.i_tx_busy) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q
                                                          : idle_cnt_q + TW'(1);
                    if ((TIMEOUT != 0) && (idle_cnt_q == IDLE_LAST)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and counter registers; reset gives source 0 first priority
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_q     <= IW'(NSRC - 1);
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Strobe and ready are held low while reset is asserted so no byte can
    // be taken from a source during the reset cycle itself.
    assign bus.o_tx_stb  = w_tx_stb & ~i_reset;
    assign bus.o_tx_data = w_tx_data;
    assign bus.o_ready   = w_ready & {NSRC{~i_reset}};
    assign bus.o_grant   = grant_q;
    assign bus.o_busy    = (state_q == ST_HOLD);

endmodule : uart_tx_arbiter
`default_nettype wire
